ps2_rx_frame_ctrl: RTL and testbench
====================================

// Module: ps2_rx_frame_ctrl
// PURPOSE
//  Receive-side frame controller for the PS/2 keyboard port. Synchronises and filters ps2_clk/ps2_data.
//  Sequences 11-bit frames: start, 8 data bits LSB-first, odd parity, stop.
//  Checks parity as y = ~^data: the count of ones across the 8 data bits plus the parity bit must be odd.
//  Delivers bytes to the scan-code decoder over a valid/ready handshake and flags bad frames.
// PARAMETERS
//  SYNC_STAGES  2     flops in each input synchroniser (min 2)
//  FILT_LEN     4     consecutive identical samples required before the filtered ps2_clk changes
//  TIMEOUT_CYC  5000  idle clk cycles mid-frame before abort (used only with PS2_RX_TIMEOUT_EN)
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  ps2_clk     in   1  raw PS/2 clock pin, asynchronous
//  ps2_data    in   1  raw PS/2 data pin, asynchronous
//  rx_data     out  8  received byte; valid while rx_valid=1
//  rx_valid    out  1  byte available; held until accepted
//  rx_ready    in   1  consumer accepts the byte when rx_valid & rx_ready
//  parity_err  out  1  1-cycle pulse: parity mismatch, frame dropped
//  frame_err   out  1  1-cycle pulse: stop bit = 0 (or timeout), frame dropped
//  overrun     out  1  1-cycle pulse: good frame lost because the holding register was full
//  busy        out  1  1 while FSM is not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - all outputs 0, FSM=IDLE
//  - synchronisers and filter preset to 1 (bus idle high)
//  Edge detect:
//  - filtered clock follows the synchronised pin after FILT_LEN equal samples
//  - fall_evt = 1-cycle pulse on a filtered 1->0 transition
//  - pin-to-fall_evt latency = SYNC_STAGES+FILT_LEN cycles; data is sampled in the fall_evt cycle
//  FSM, advancing only on fall_evt:
//  - IDLE:   data=0 -> DATA, bit count=0. data=1 -> stay IDLE (glitch start).
//  - DATA:   shift into sr[7:0] LSB-first; after 8th bit -> PARITY.
//  - PARITY: capture p. Go to STOP.
//  - STOP:   data=1 and p==~^sr -> deliver. data=1 and mismatch -> parity_err.
//            data=0 -> frame_err (takes priority over parity).
//            Always -> IDLE.
//  Delivery, evaluated in the cycle after the STOP fall_evt:
//  - if !rx_valid, or rx_valid & rx_ready in that same cycle: load rx_data=sr; rx_valid=1
//  - else overrun=1 and the held byte is kept unchanged
//  - latency: stop-bit fall_evt -> rx_valid high = 1 clk
//  Handshake:
//  - rx_valid clears the cycle after rx_valid & rx_ready; rx_data is stable while rx_valid=1
//  - rx_ready has no effect while rx_valid=0
//  Error pulses:
//  - parity_err, frame_err and overrun are mutually exclusive
//  - each is exactly 1 clk, at the same cycle offset as delivery
//  Reset asserted mid-frame: partial frame discarded; receive restarts at the next start bit.
//  busy = (state != IDLE).
// CONFIGURATION
//  PS2_RX_TIMEOUT_EN defined:
//  - counter clears on every fall_evt and counts while not IDLE
//  - at TIMEOUT_CYC: FSM -> IDLE, frame_err pulses 1 clk, no byte delivered
//  PS2_RX_TIMEOUT_EN undefined:
//  - no counter; FSM waits indefinitely for the next edge
//  - TIMEOUT_CYC ignored
// TESTING
//  1. Frame 0x1C, p=0, stop=1, rx_ready=1 -> one rx_valid pulse with rx_data=0x1C; no error pulses.
//  2. Frame 0xF0 with p=0 (correct p=1) -> parity_err 1 clk; rx_valid stays 0.
//  3. Frame 0x1C with stop=0 -> frame_err 1 clk, parity_err 0; FSM back in IDLE (busy=0).
//  4. rx_ready=0; frames 0x1C then 0x32 -> rx_data holds 0x1C, overrun pulses once.
//     Raise rx_ready -> rx_valid drops the next cycle.
//  5. 2-cycle low glitch on ps2_clk (< FILT_LEN) -> no fall_evt; FSM stays IDLE; rx_valid stays 0.
//     Assert rst_n=0 after 4 data bits -> outputs 0 at once; then a clean 0x1C frame is received.
//  6. With PS2_RX_TIMEOUT_EN, TIMEOUT_CYC=100: stop clock after 3 bits -> frame_err at cycle 100; busy=0.
//     Without the macro -> busy stays 1.

Source files
------------

// File: rtl/ps2_rx_frame_ctrl.sv
// ============================================================================
// ps2_rx_frame_ctrl
// ----------------------------------------------------------------------------
// Receive-side frame controller for a PS/2 keyboard port.
//  - Synchronises the asynchronous ps2_clk / ps2_data pins and filters ps2_clk
//    so that a level change is accepted only after FILT_LEN identical samples.
//  - A 1->0 transition of the filtered clock (fall_evt) advances an 11-bit frame
//    sequencer: start(0), 8 data bits LSB-first, odd parity, stop(1).
//  - Good bytes are handed over a valid/ready handshake; bad or lost frames
//    raise one-cycle error pulses.
//
// Optional feature (compile-time macro): PS2_RX_TIMEOUT_EN
//  When defined, a frame that sees no clock edge for TIMEOUT_CYC cycles is
//  aborted with a frame_err pulse. When undefined the sequencer waits forever.
//
// Ports:
//  clk        in   system clock
//  rst_n      in   asynchronous active-low reset
//  ps2_clk    in   raw PS/2 clock pin (asynchronous)
//  ps2_data   in   raw PS/2 data pin (asynchronous)
//  rx_data    out  received byte, stable while rx_valid=1
//  rx_valid   out  byte available, held until rx_valid & rx_ready
//  rx_ready   in   consumer accepts the byte
//  parity_err out  1-cycle pulse: parity mismatch, frame dropped
//  frame_err  out  1-cycle pulse: stop bit 0 (or timeout), frame dropped
//  overrun    out  1-cycle pulse: good frame lost, holding register full
//  busy       out  1 while a frame is in progress
// ============================================================================
module ps2_rx_frame_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("ps2_rx_frame_ctrl: illegal parameter value");
    end

    localparam int FCW = $clog2(FILT_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Odd parity: ones in data plus parity bit must be odd.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_p0;
    logic [SYNC_STAGES-1:0] data_sync_p0;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_filt_p1;
    logic [FCW-1:0]         filt_cnt;
    logic                   fall_evt;
    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             sr;
    logic                   par_bit;

    // ---- stage p0: input synchronisers, preset to bus-idle high ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_p0  <= '1;
            data_sync_p0 <= '1;
        end else begin
            clk_sync_p0  <= {clk_sync_p0[SYNC_STAGES-2:0], ps2_clk};
            data_sync_p0 <= {data_sync_p0[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_p0[SYNC_STAGES-1];
    assign data_s = data_sync_p0[SYNC_STAGES-1];

    // ---- stage p1: glitch filter and falling-edge event ----
    // The counter tracks how many consecutive samples disagree with the
    // filtered level; the level flips on the FILT_LEN-th disagreeing sample,
    // which also fires fall_evt in the same edge when the old level was 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt_p1 <= 1'b1;
            filt_cnt    <= '0;
            fall_evt    <= 1'b0;
        end else begin
            fall_evt <= 1'b0;
            if (clk_s != clk_filt_p1) begin
                if (filt_cnt == FCW'(FILT_LEN - 1)) begin
                    clk_filt_p1 <= clk_s;
                    filt_cnt    <= '0;
                    fall_evt    <= clk_filt_p1;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] tmo_cnt;
`endif

    // ---- stage p2: frame sequencer, delivery and error reporting ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            par_bit    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (fall_evt) begin
                case (state)
                    S_IDLE: begin
                        // A start bit reading 1 is a glitch; stay idle.
                        if (!data_s) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        sr      <= {data_s, sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= data_s;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!data_s) begin
                            frame_err <= 1'b1;
                        end else if (!parity_ok(sr, par_bit)) begin
                            parity_err <= 1'b1;
                        end else if (!rx_valid || rx_ready) begin
                            // Slot is free, or is being emptied this very cycle.
                            rx_data  <= sr;
                            rx_valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end

`ifdef PS2_RX_TIMEOUT_EN
            if (fall_evt || state == S_IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt == TCW'(TIMEOUT_CYC - 1)) begin
                tmo_cnt   <= '0;
                state     <= S_IDLE;
                frame_err <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_rx_frame_ctrl.sv
// ============================================================================
// tb_ps2_rx_frame_ctrl
// Scoreboard bench: stimulus pushes the expected byte / error event into
// queues, a negedge monitor pops and compares whenever the DUT presents a
// handshake or an error pulse.
// ============================================================================
module tb_ps2_rx_frame_ctrl;

    localparam int H = 12;   // PS/2 half-bit period in system clocks

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    ps2_rx_frame_ctrl #(
        .SYNC_STAGES(2),
        .FILT_LEN   (4),
        .TIMEOUT_CYC(100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_bytes[$];
    int         exp_errs[$];   // 1 parity_err, 2 frame_err, 3 overrun

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: decide outcome of a full frame from the protocol rules.
    task automatic expect_frame(input logic [7:0] b, input logic p, input logic stop,
                                input logic slot_full);
        if (!stop)
            exp_errs.push_back(2);
        else if ((($countones(b) + int'(p)) % 2) != 1)
            exp_errs.push_back(1);
        else if (slot_full)
            exp_errs.push_back(3);
        else
            exp_bytes.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic p, input logic stop,
                              input int nbits);
        logic [10:0] bits;
        bits = {stop, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (2 * H) @(posedge clk);
        #1;
    endtask

    function automatic int out_word();
        return int'({rx_valid, parity_err, frame_err, overrun, busy, rx_data});
    endfunction

    // ---------------- monitor ----------------
    logic       prev_v, prev_r, prev_pe, prev_fe, prev_ov;
    logic [7:0] prev_d;

    always @(negedge clk) begin : mon
        int n;
        int k;
        if (!rst_n) begin
            prev_v = 0; prev_r = 0; prev_pe = 0; prev_fe = 0; prev_ov = 0; prev_d = 0;
        end else begin
            n = int'(parity_err) + int'(frame_err) + int'(overrun);
            if (n > 1) begin
                check("err_exclusive", n, 1);
            end else if (n == 1) begin
                k = parity_err ? 1 : (frame_err ? 2 : 3);
                if (exp_errs.size() == 0)
                    check("unexpected_err", k, 0);
                else
                    check("err_kind", k, exp_errs.pop_front());
                if ((parity_err && prev_pe) || (frame_err && prev_fe) || (overrun && prev_ov))
                    check("err_width", k, 0);
            end
            if (rx_valid && rx_ready) begin
                if (exp_bytes.size() == 0)
                    check("unexpected_byte", exp_bytes.size(), 1);
                else
                    check("rx_data", rx_data, exp_bytes.pop_front());
            end
            if (prev_v && !prev_r) begin
                check("hold_valid", rx_valid, 1);
                if (rx_valid) check("hold_data", rx_data, prev_d);
            end
            prev_v = rx_valid; prev_r = rx_ready; prev_d = rx_data;
            prev_pe = parity_err; prev_fe = frame_err; prev_ov = overrun;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        logic       p;
        logic       stop;
        int         kind;

        repeat (3) @(posedge clk);
        #1 check("reset_outputs", out_word(), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 1: good frame 0x1C
        expect_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        check("t1_busy", busy, 0);

        // 2: 0xF0 with wrong parity
        expect_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 11);
        check("t2_valid", rx_valid, 0);

        // 3: bad stop bit
        expect_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        check("t3_busy", busy, 0);

        // 4: overrun with consumer stalled
        rx_ready = 1'b0;
        expect_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        expect_frame(8'h32, 1'b0, 1'b1, 1'b1);
        send_frame(8'h32, 1'b0, 1'b1, 11);
        @(negedge clk);
        check("t4_held_valid", rx_valid, 1);
        check("t4_held_data", rx_data, 8'h1C);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_drop", rx_valid, 0);
        #1;

        // 5a: short clock glitch is filtered out
        @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("t5_glitch_busy", busy, 0);
        check("t5_glitch_valid", rx_valid, 0);

        // 5b: reset in the middle of a frame, then a clean frame
        send_frame(8'h5A, 1'b1, 1'b1, 5);
        check("t5_midframe_busy", busy, 1);
        rst_n = 1'b0;
        #1 check("t5_reset_outputs", out_word(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11);

        // Randomised frames
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom);
            kind = int'($urandom_range(0, 5));
            p    = ~^b;
            stop = 1'b1;
            if (kind == 4) p = ~p;
            if (kind == 5) begin
                stop = 1'b0;
                p    = 1'($urandom);
            end
            expect_frame(b, p, stop, 1'b0);
            send_frame(b, p, stop, 11);
            repeat (int'($urandom_range(0, 10))) @(posedge clk);
            #1;
        end
        check("rand_busy", busy, 0);

        // 6: clock stops after 3 data bits
`ifdef PS2_RX_TIMEOUT_EN
        exp_errs.push_back(2);
        send_frame(8'hA5, 1'b0, 1'b1, 4);
        repeat (200) @(posedge clk);
        #1 check("t6_timeout_busy", busy, 0);
`else
        send_frame(8'hA5, 1'b0, 1'b1, 4);
        repeat (200) @(posedge clk);
        #1 check("t6_stall_busy", busy, 1);
`endif
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        repeat (50) @(posedge clk);
        #1 check("bytes_drained", exp_bytes.size(), 0);
        check("errs_drained", exp_errs.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
